// File: rtl/ls163_timer_ctrl.sv
// Interval timer controller for a 74LS163-style 4-bit counter: preloads the
// counter, runs it for L cycles per period and checks that RCO arrives on time.
module ls163_timer_ctrl (
  input  logic       clk,
  input  logic       reset_bar,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] interval,
  input  logic [3:0] repeat_cnt,
  output logic       busy,
  output logic       expired,
  output logic       fault,
  output logic [3:0] reps_left,
  output logic       cnt_clear_bar,
  output logic       cnt_load_bar,
  output logic       cnt_ent,
  output logic       cnt_enp,
  output logic [3:0] cnt_d,
  input  logic       cnt_rco
);

  typedef enum logic [2:0] {
    S_CLR,
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FAULT
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] last_reg, last_next;        // L-1: run_cnt value of the final RUN cycle
  logic [3:0] preload_reg, preload_next;
  logic [3:0] reps_reg, reps_next;
  logic [3:0] run_cnt_reg, run_cnt_next;
  logic       expired_reg, expired_next;
  logic       at_last;

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state_reg   <= S_CLR;
      last_reg    <= 4'd0;
      preload_reg <= 4'd0;
      reps_reg    <= 4'd0;
      run_cnt_reg <= 4'd0;
      expired_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      last_reg    <= last_next;
      preload_reg <= preload_next;
      reps_reg    <= reps_next;
      run_cnt_reg <= run_cnt_next;
      expired_reg <= expired_next;
    end
  end

  assign at_last = (run_cnt_reg == last_reg);

  always_comb begin
    state_next   = state_reg;
    last_next    = last_reg;
    preload_next = preload_reg;
    reps_next    = reps_reg;
    run_cnt_next = (state_reg == S_RUN) ? run_cnt_reg + 4'd1 : 4'd0;
    expired_next = 1'b0;

    case (state_reg)
      S_CLR: state_next = S_IDLE;

      S_IDLE, S_FAULT: begin
        if (start) begin
          state_next   = S_LOAD;
          // interval 0 means 16, which the 4-bit wrap gives for free
          last_next    = interval - 4'd1;
          preload_next = 4'd0 - interval;
          reps_next    = repeat_cnt;
        end else if (abort && state_reg == S_FAULT) begin
          state_next = S_CLR;
        end
      end

      S_LOAD: state_next = abort ? S_CLR : S_RUN;

      S_RUN: begin
        if (abort) begin
          state_next = S_CLR;
        end else if (cnt_rco && at_last) begin
          expired_next = 1'b1;
          if (reps_reg == 4'd1) begin
            state_next = S_IDLE;
            reps_next  = 4'd0;
          end else begin
            state_next = S_LOAD;
            if (reps_reg != 4'd0) reps_next = reps_reg - 4'd1;
          end
        end else if (cnt_rco || at_last) begin
          state_next = S_FAULT;
        end
      end

      default: state_next = S_CLR;
    endcase
  end

  assign busy          = (state_reg == S_LOAD) || (state_reg == S_RUN);
  assign fault         = (state_reg == S_FAULT);
  assign expired       = expired_reg;
  assign reps_left     = reps_reg;
  assign cnt_d         = preload_reg;
  assign cnt_clear_bar = (state_reg != S_CLR);
  assign cnt_load_bar  = (state_reg != S_LOAD);
  assign cnt_ent       = (state_reg == S_RUN);
  assign cnt_enp       = (state_reg == S_RUN);

endmodule

// File: tb/tb_ls163_timer_ctrl.sv
// Bench for ls163_timer_ctrl: a behavioural 74LS163 closes the loop, and a
// period-position model of the timer predicts every output each cycle.
module tb_ls163_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset_bar;
  logic       start;
  logic       abort;
  logic [3:0] interval;
  logic [3:0] repeat_cnt;
  logic       busy;
  logic       expired;
  logic       fault;
  logic [3:0] reps_left;
  logic       cnt_clear_bar;
  logic       cnt_load_bar;
  logic       cnt_ent;
  logic       cnt_enp;
  logic [3:0] cnt_d;
  logic       cnt_rco;

  always #5 clk = ~clk;

  ls163_timer_ctrl dut (
    .clk          (clk),
    .reset_bar    (reset_bar),
    .start        (start),
    .abort        (abort),
    .interval     (interval),
    .repeat_cnt   (repeat_cnt),
    .busy         (busy),
    .expired      (expired),
    .fault        (fault),
    .reps_left    (reps_left),
    .cnt_clear_bar(cnt_clear_bar),
    .cnt_load_bar (cnt_load_bar),
    .cnt_ent      (cnt_ent),
    .cnt_enp      (cnt_enp),
    .cnt_d        (cnt_d),
    .cnt_rco      (cnt_rco)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Model: mode plus position within the current period
  // (pos 0 = load cycle, pos 1..len = counting cycles).
  localparam int M_CLR  = 0;
  localparam int M_IDLE = 1;
  localparam int M_ACT  = 2;
  localparam int M_FLT  = 3;

  int m_mode = M_CLR;
  int m_pos  = 0;
  int m_len  = 16;
  int m_reps = 0;
  int m_d    = 0;
  bit m_exp  = 1'b0;
  int q      = 5;     // external counter chip contents
  int rco_mode = 0;   // 0 healthy, 1 RCO stuck low, 2 spurious RCO pulses

  function automatic logic [3:0] rnd4();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic check_outputs();
    bit act;
    act = (m_mode == M_ACT);
    check("busy", busy, act);
    check("fault", fault, m_mode == M_FLT);
    check("expired", expired, m_exp);
    check("reps_left", reps_left, m_reps);
    check("cnt_d", cnt_d, m_d);
    check("clear_bar", cnt_clear_bar, m_mode != M_CLR);
    check("load_bar", cnt_load_bar, !(act && m_pos == 0));
    check("ent", cnt_ent, act && m_pos > 0);
    check("enp", cnt_enp, act && m_pos > 0);
  endtask

  // Called at a falling edge: check, drive inputs, predict the next rising edge.
  task automatic cycle(input bit st, input bit ab, input logic [3:0] iv, input logic [3:0] rp);
    bit rco;
    bit last;
    check_outputs();
    start      = st;
    abort      = ab;
    interval   = iv;
    repeat_cnt = rp;
    rco = cnt_ent && (q == 15);
    if (rco_mode == 1) rco = 1'b0;
    else if (rco_mode == 2 && cnt_ent && $urandom_range(0, 11) == 0) rco = 1'b1;
    cnt_rco = rco;

    if (!cnt_clear_bar) q = 0;
    else if (!cnt_load_bar) q = int'(cnt_d);
    else if (cnt_ent && cnt_enp) q = (q + 1) % 16;

    m_exp = 1'b0;
    case (m_mode)
      M_CLR: m_mode = M_IDLE;
      M_IDLE, M_FLT: begin
        if (st) begin
          m_len  = (iv == 0) ? 16 : int'(iv);
          m_d    = (16 - m_len) % 16;
          m_reps = int'(rp);
          m_mode = M_ACT;
          m_pos  = 0;
          $display("start: L=%0d reps=%0d rco_mode=%0d at %0t", m_len, m_reps, rco_mode, $time);
        end else if (ab && m_mode == M_FLT) begin
          m_mode = M_CLR;
        end
      end
      M_ACT: begin
        if (ab) m_mode = M_CLR;
        else if (m_pos == 0) m_pos = 1;
        else begin
          last = (m_pos == m_len);
          if (rco && last) begin
            m_exp = 1'b1;
            if (m_reps == 1) begin
              m_reps = 0;
              m_mode = M_IDLE;
            end else begin
              m_pos = 0;
              if (m_reps > 0) m_reps--;
            end
          end else if (rco || last) begin
            m_mode = M_FLT;
          end else begin
            m_pos++;
          end
        end
      end
      default: m_mode = M_CLR;
    endcase
    @(negedge clk);
  endtask

  // Called at a falling edge; asserts reset mid-cycle, returns at a falling edge.
  task automatic do_reset();
    #2 reset_bar = 1'b0;
    #1;
    m_mode = M_CLR;
    m_pos  = 0;
    m_reps = 0;
    m_d    = 0;
    m_exp  = 1'b0;
    check_outputs();
    cnt_rco = 1'b0;
    @(negedge clk);
    check_outputs();
    q = 0;
    reset_bar = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, rnd4(), rnd4());
  endtask

  initial begin
    reset_bar  = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    interval   = 4'd0;
    repeat_cnt = 4'd0;
    cnt_rco    = 1'b0;
    @(negedge clk);
    do_reset();
    idle_cycles(2);

    cycle(1'b1, 1'b0, 4'd3, 4'd2);           // two periods of length 3
    idle_cycles(10);
    cycle(1'b1, 1'b0, 4'd0, 4'd1);           // interval 0 means 16
    idle_cycles(20);
    cycle(1'b1, 1'b0, 4'd5, 4'd0);           // continuous, then abort mid-run
    idle_cycles(20);
    cycle(1'b0, 1'b1, rnd4(), rnd4());
    idle_cycles(10);

    rco_mode = 1;                            // counter never produces RCO
    cycle(1'b1, 1'b0, 4'd4, 4'd3);
    idle_cycles(8);
    rco_mode = 0;
    cycle(1'b1, 1'b0, 4'd2, 4'd1);           // restart out of FAULT
    idle_cycles(6);

    cycle(1'b1, 1'b0, 4'd3, 4'd0);           // abort lands on the RCO cycle
    cycle(1'b0, 1'b0, rnd4(), rnd4());
    cycle(1'b1, 1'b0, rnd4(), rnd4());
    cycle(1'b0, 1'b0, rnd4(), rnd4());
    cycle(1'b0, 1'b1, rnd4(), rnd4());
    idle_cycles(4);

    cycle(1'b1, 1'b0, 4'd6, 4'd3);           // async reset in the middle of a run
    idle_cycles(4);
    do_reset();
    idle_cycles(3);

    for (int s = 0; s < 60; s++) begin
      int rst_at;
      rco_mode = ($urandom_range(0, 5) == 0) ? 1 : (($urandom_range(0, 3) == 0) ? 2 : 0);
      rst_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 39)) : -1;
      cycle(1'b0, 1'b1, rnd4(), rnd4());
      cycle(1'b0, 1'b0, rnd4(), rnd4());
      cycle(1'b1, 1'b0, rnd4(), 4'($urandom_range(0, 4)));
      for (int c = 0; c < 40; c++) begin
        bit st;
        bit ab;
        st = ($urandom_range(0, 9) == 0);
        ab = !st && ($urandom_range(0, 59) == 0);
        if (c == rst_at) do_reset();
        cycle(st, ab, rnd4(), rnd4());
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
